// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer: left-shifts a 32-bit operand until normalized and reports the shift amount.
// Optional coarse 8-bit step when SHIFT_NORM_FAST_EN is defined.
module shift_normalizer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic        mode,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic [4:0]  shamt,
    output logic        zero
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]  state;
    logic [31:0] r;
    logic [4:0]  cnt;
    logic        mode_q;
    logic        degenerate;
    logic        normalized;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        degenerate = (a == 32'd0) || (mode && (a == 32'hFFFF_FFFF));
        normalized = mode_q ? (r[31] ^ r[30]) : r[31];
    end

`ifdef SHIFT_NORM_FAST_EN
    logic coarse;

    // Signed needs nine equal top bits so that eight of them are redundant.
    always_comb begin
        coarse = mode_q ? ((r[31:23] == 9'h000) || (r[31:23] == 9'h1FF))
                        : (r[31:24] == 8'h00);
    end
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            r      <= '0;
            cnt    <= '0;
            mode_q <= 1'b0;
            out    <= '0;
            shamt  <= '0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        r      <= a;
                        cnt    <= '0;
                        mode_q <= mode;
                        if (degenerate) begin
                            out   <= a;
                            shamt <= '0;
                            zero  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (normalized) begin
                        out   <= r;
                        shamt <= cnt;
                        zero  <= 1'b0;
                        state <= DONE;
                    end
`ifdef SHIFT_NORM_FAST_EN
                    else if (coarse) begin
                        r   <= r << 8;
                        cnt <= cnt + 5'd8;
                    end
`endif
                    else begin
                        r   <= r << 1;
                        cnt <= cnt + 5'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_normalizer.sv
// Self-checking bench for shift_normalizer: directed table, hand-written corner sequences,
// and random operands against a leading-bit-count reference model.
module tb_shift_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic        mode;
    logic        busy;
    logic        done;
    logic [31:0] out;
    logic [4:0]  shamt;
    logic        zero;

    int checks = 0;
    int errors = 0;

    shift_normalizer dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .mode  (mode),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .shamt (shamt),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic        mode;
        logic [31:0] exp_out;
        logic [4:0]  exp_shamt;
        logic        exp_zero;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input int n, input logic degen);
        if (degen) return 1;
`ifdef SHIFT_NORM_FAST_EN
        return n / 8 + n % 8 + 2;
`else
        return n + 2;
`endif
    endfunction

    // Reference: count leading zeros (unsigned) or redundant sign bits (signed) directly.
    function automatic void model(input logic [31:0] av, input logic m, output logic [31:0] o,
                                  output logic [4:0] s, output logic z, output int lat);
        int n = 0;
        if (av == 0 || (m && av == 32'hFFFF_FFFF)) begin
            o = av; s = 0; z = 1'b1; lat = exp_latency(0, 1'b1);
        end else begin
            if (!m) while (!av[31-n]) n++;
            else    while (av[30-n] == av[31]) n++;
            o = av << n; s = 5'(n); z = 1'b0; lat = exp_latency(n, 1'b0);
        end
    endfunction

    // Issues one request; lat is the cycle (relative to accept edge T) where done was seen, 0 on timeout.
    task automatic run_op(input logic [31:0] av, input logic m, output int lat);
        @(negedge clk);
        start = 1'b1; a = av; mode = m;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 80; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        check("busy_at_done", busy, 1'b1);
        @(posedge clk); #1;
        check("done_single_cycle", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
    endtask

    vec_t vecs[$];

    initial begin
        int lat;
        int done_cnt;
        int done_at;
        logic [31:0] m_out;
        logic [4:0]  m_s;
        logic        m_z;
        int          m_lat;

        vecs.push_back('{32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0});
        vecs.push_back('{32'hFFFF_FF80, 1'b1, 32'h8000_0000, 5'd24, 1'b0});
        vecs.push_back('{32'h0000_1234, 1'b1, 32'h48D0_0000, 5'd18, 1'b0});
        vecs.push_back('{32'h0000_1234, 1'b0, 32'h91A0_0000, 5'd19, 1'b0});
        vecs.push_back('{32'h0000_0000, 1'b0, 32'h0000_0000, 5'd0,  1'b1});
        vecs.push_back('{32'h0000_0000, 1'b1, 32'h0000_0000, 5'd0,  1'b1});
        vecs.push_back('{32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 5'd0,  1'b1});
        vecs.push_back('{32'h8000_0000, 1'b0, 32'h8000_0000, 5'd0,  1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 5'd0,  1'b0});
        vecs.push_back('{32'h4000_0000, 1'b1, 32'h4000_0000, 5'd0,  1'b0});
        vecs.push_back('{32'h8000_0000, 1'b1, 32'h8000_0000, 5'd0,  1'b0});
        vecs.push_back('{32'hC000_0000, 1'b1, 32'h8000_0000, 5'd1,  1'b0});
        vecs.push_back('{32'h0080_0000, 1'b1, 32'h4000_0000, 5'd7,  1'b0});

        rst = 1'b1; start = 1'b0; a = '0; mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_out", out, 32'd0);
        check("reset_shamt", shamt, 5'd0);
        check("reset_zero", zero, 1'b0);
        rst = 1'b0;

        // Directed table.
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].mode, lat);
            check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
            check($sformatf("vec%0d_shamt", i), shamt, vecs[i].exp_shamt);
            check($sformatf("vec%0d_zero", i), zero, vecs[i].exp_zero);
            check($sformatf("vec%0d_latency", i), lat,
                  exp_latency(int'(vecs[i].exp_shamt), vecs[i].exp_zero));
        end

        // Start held into the done cycle of a degenerate op must not be accepted.
        @(negedge clk);
        start = 1'b1; a = 32'h0; mode = 1'b0;
        @(posedge clk); #1;
        check("hold_start_done", done, 1'b1);
        a = 32'h8000_0000;
        @(posedge clk); #1;
        start = 1'b0;
        check("hold_start_ignored", busy, 1'b0);
        check("hold_start_result_kept", zero, 1'b1);

        // Start pulsed while busy at T+5 is ignored, not queued.
        @(negedge clk);
        start = 1'b1; a = 32'h1; mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        done_cnt = 0; done_at = 0;
        for (int k = 1; k <= 80; k++) begin
            if (k == 5) begin start = 1'b1; a = 32'h8000_0000; end
            if (k == 6) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            @(posedge clk); #1;
        end
        check("busy_ignore_done_count", done_cnt, 1);
        check("busy_ignore_latency", done_at, exp_latency(31, 1'b0));
        check("busy_ignore_shamt", shamt, 5'd31);
        check("busy_ignore_out", out, 32'h8000_0000);

        // Reset asserted in cycle T+10 aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; a = 32'h1; mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        done_cnt = 0;
        for (int k = 1; k < 10; k++) begin
            if (done) done_cnt++;
            @(posedge clk); #1;
        end
        if (done) done_cnt++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_no_done", done_cnt, 0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_out", out, 32'd0);
        check("abort_shamt", shamt, 5'd0);
        check("abort_zero", zero, 1'b0);
        run_op(32'h0000_1234, 1'b1, lat);
        check("post_reset_out", out, 32'h48D0_0000);
        check("post_reset_shamt", shamt, 5'd18);
        check("post_reset_latency", lat, exp_latency(18, 1'b0));

        // Random operands with a spread of leading-bit counts.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            logic        rm;
            rm = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       ra = 32'h0;
                1:       ra = 32'hFFFF_FFFF;
                2:       ra = ~($urandom >> $urandom_range(0, 31));
                default: ra = $urandom >> $urandom_range(0, 31);
            endcase
            model(ra, rm, m_out, m_s, m_z, m_lat);
            run_op(ra, rm, lat);
            check($sformatf("rnd%0d_out a=%0h m=%0d", i, ra, rm), out, m_out);
            check($sformatf("rnd%0d_shamt", i), shamt, m_s);
            check($sformatf("rnd%0d_zero", i), zero, m_z);
            check($sformatf("rnd%0d_latency", i), lat, m_lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_normalizer.md
# shift_normalizer

Multi-cycle normalizer for the datapath: it takes a 32-bit operand and left-shifts it until it is normalized, reporting the shift amount. It is the inverse of the barrel shifter. The shifter consumes an operand and a shift amount; this block consumes an operand and produces the shift amount that normalizes it. It serves count-leading-zeros style instructions and the shift/normalize step of the multi-cycle mul/div path. It uses a start/done handshake and processes one operand at a time.

## Interface
- No parameters.
- `clk`  input  1  system clock, all state updates on rising edge
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  request; sampled only in IDLE
- `a`  input  32  operand, sampled with `start`
- `mode`  input  1  0 = unsigned (count leading zeros), 1 = signed (count redundant sign bits); sampled with `start`
- `busy`  output  1  high whenever state is not IDLE
- `done`  output  1  single-cycle pulse when the result registers update
- `out`  output  32  normalized operand
- `shamt`  output  5  left-shift amount applied
- `zero`  output  1  operand had no normalizable bit

## Operation
- States:
  - **IDLE:** waits for `start`.
  - **SHIFT:** shifts the working register `r` and counts in `cnt[4:0]`.
  - **DONE:** holds for one cycle, then returns to IDLE.
- IDLE with `start=1`:
  - Load `r<=a`, `cnt<=0`, latch `mode`.
  - If the operand is degenerate, go directly to DONE. Unsigned degenerate: `a==0`. Signed degenerate: `a==0` or `a==32'hFFFF_FFFF`.
  - Otherwise go to SHIFT.
- SHIFT, normalized test:
  - Unsigned: `r[31]==1`.
  - Signed: `r[31]!=r[30]`.
  - If normalized, go to DONE. Otherwise `r<=r<<1` (zero fill) and `cnt<=cnt+1`.
- Entry to DONE: `out<=r`, `shamt<=cnt` and `zero<=degenerate` are written together.
  - Degenerate case: `out=a`, `shamt=0`, `zero=1`.
- DONE: `done=1` for exactly one cycle, then go to IDLE.
- Result range:
  - Unsigned: `shamt` is 0..31.
  - Signed: `shamt` is 0..30, so `cnt` never overflows.
- `out`, `shamt` and `zero` hold their values until the next DONE entry.
- `start` while in SHIFT or DONE is ignored. It is not queued.

## Timing
- `start` sampled at edge T. Let n be the final shift amount.
- `done` is high in cycle T+n+2. `busy` is high in cycles T+1..T+n+2.
- Degenerate operand: `done` is high in T+1. `busy` is high only in T+1.
- An already-normalized operand (n=0): `done` is high in T+2.
- `start` high in the same cycle as `done` is ignored. The next accept happens at the earliest in the cycle after `done`.
- Reset:
  - Values: state IDLE, `busy=0`, `done=0`, `out=0`, `shamt=0`, `zero=0`, `r=0`, `cnt=0`.
  - Reset has priority over `start`.
  - Reset mid-operation aborts the operation with no `done` pulse.

## Configuration
- `SHIFT_NORM_FAST_EN` defined: SHIFT gains a coarse step that is checked before the 1-bit step.
  - Coarse condition, unsigned: `r[31:24]==0`.
  - Coarse condition, signed: `r[31:23]` all bits equal.
  - Coarse action (operand not degenerate): `r<=r<<8`, `cnt<=cnt+8` in one cycle.
  - Latency becomes T + floor(n/8) + (n mod 8) + 2.
  - Results are identical to the 1-bit-per-cycle build.
- Undefined: 1 bit per cycle only, latency as given in Timing.

## Test plan
- Unsigned, `a=32'h0000_0001`:
  - Required: `out=32'h8000_0000`, `shamt=31`, `zero=0`.
  - `done` at T+33 (fast build: T+12).
- Signed, `a=32'hFFFF_FF80`:
  - Required: `out=32'h8000_0000`, `shamt=24`.
  - `done` at T+26 (fast build: T+5).
- Same operand `a=32'h0000_1234` in both modes:
  - Signed: `out=32'h48D0_0000`, `shamt=18`.
  - Unsigned: `out=32'h91A0_0000`, `shamt=19`.
- Degenerate and already-normalized operands:
  - `a=0` in either mode: `zero=1`, `out=0`, `shamt=0`, `done` at T+1.
  - `a=32'hFFFF_FFFF`, signed: `zero=1`, `out=32'hFFFF_FFFF`, `shamt=0`, `done` at T+1.
  - `a=32'h8000_0000`, unsigned: `shamt=0`, `done` at T+2.
- Start ignored while busy:
  - Apply `start` with `a=1` (unsigned), then pulse `start` with `a=32'h8000_0000` at T+5.
  - Required: the second request is ignored and the only result is `shamt=31`.
- Reset mid-operation:
  - Assert `rst` at T+10 of an `a=1` operation.
  - Required: no `done` pulse, `busy=0`, all outputs 0 the cycle after.
  - A new `start` after reset completes normally.
